// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch unit and the control unit: word/address
// widths, the opcodes the fetcher must recognise, and the fetch FSM states.
package cpu_pkg;

   localparam int INSTR_WIDTH = 20;
   localparam int PC_BITS     = 5;

   localparam logic [3:0] OPC_NOP  = 4'h0;
   localparam logic [3:0] OPC_HALT = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

   // True when the opcode field terminates the program.
   function automatic logic is_halt(input logic [3:0] opcode);
      return (opcode == OPC_HALT);
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Program-load bus: the loader (master) writes words into the fetch unit's
// program memory while the fetch unit (slave) is idle.
interface instr_fetch_if #(
   parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
   parameter int PC_BITS     = cpu_pkg::PC_BITS
) ();

   logic                   load_en;
   logic [PC_BITS-1:0]     load_addr;
   logic [INSTR_WIDTH-1:0] load_data;

   modport master (output load_en, load_addr, load_data);
   modport slave  (input  load_en, load_addr, load_data);

endinterface

// File: rtl/instr_mem.sv
// Program memory: synchronous write, asynchronous read, contents survive reset.
module instr_mem #(
   parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
   parameter int PC_BITS     = cpu_pkg::PC_BITS
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [PC_BITS-1:0]     waddr,
   input  logic [INSTR_WIDTH-1:0] wdata,
   input  logic [PC_BITS-1:0]     raddr,
   output logic [INSTR_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << PC_BITS;

   logic [INSTR_WIDTH-1:0] mem_r [DEPTH];

   // Write port; no reset so a reset cannot wipe the loaded program.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: loads a program while idle, then streams one word per
// cycle into the CPU until a HALT opcode is reached. The HALT word itself is never forwarded.
module instr_fetch import cpu_pkg::*; #(
   parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
   parameter int PC_BITS     = cpu_pkg::PC_BITS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stall,
   instr_fetch_if.slave           load_bus,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic [PC_BITS-1:0]     pc,
   output logic                   running,
   output logic                   halted
);

   localparam logic [INSTR_WIDTH-1:0] NOP_WORD = {INSTR_WIDTH{1'b0}};
   localparam logic [PC_BITS-1:0]     PC_ZERO  = {PC_BITS{1'b0}};

   fetch_state_e           state_r;
   fetch_state_e           state_s;
   logic [PC_BITS-1:0]     pc_r;
   logic [PC_BITS-1:0]     pc_s;
   logic [INSTR_WIDTH-1:0] instr_r;
   logic [INSTR_WIDTH-1:0] instr_s;
   logic                   running_r;
   logic                   halted_r;
   logic                   mem_we_s;
   logic [INSTR_WIDTH-1:0] rd_data_s;

   // Loads are accepted only in IDLE, and a simultaneous reset suppresses them.
   assign mem_we_s = load_bus.load_en & (state_r == ST_IDLE) & ~rst;

   instr_mem #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .PC_BITS     (PC_BITS)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we_s),
      .waddr (load_bus.load_addr),
      .wdata (load_bus.load_data),
      .raddr (pc_r),
      .rdata (rd_data_s)
   );

   // Next-state, next-pc and next-instruction selection.
   always_comb begin
      state_s = state_r;
      pc_s    = pc_r;
      instr_s = NOP_WORD;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_RUN;
               pc_s    = PC_ZERO;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stall) begin
               pc_s = pc_r;
            end else if (is_halt(rd_data_s[INSTR_WIDTH-1 -: 4])) begin
               state_s = ST_HALTED;
            end else begin
               instr_s = rd_data_s;
               pc_s    = pc_r + PC_BITS'(1);
            end
         end
         ST_HALTED: begin
            if (start) begin
               state_s = ST_RUN;
               pc_s    = PC_ZERO;
            end else begin
               state_s = ST_HALTED;
            end
         end
         default: begin
            state_s = ST_IDLE;
            pc_s    = PC_ZERO;
         end
      endcase
   end

   // State, pc and output registers; reset overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         pc_r      <= PC_ZERO;
         instr_r   <= NOP_WORD;
         running_r <= 1'b0;
         halted_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         pc_r      <= pc_s;
         instr_r   <= instr_s;
         running_r <= (state_s == ST_RUN);
         halted_r  <= (state_s == ST_HALTED);
      end
   end

   assign instruction = instr_r;
   assign pc          = pc_r;
   assign running     = running_r;
   assign halted      = halted_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with hand-computed expectations.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stall;
   logic [19:0] instruction;
   logic [4:0]  pc;
   logic        running;
   logic        halted;

   int total = 0;
   int bad   = 0;

   logic [19:0] exp_mem [32];

   instr_fetch_if #(.INSTR_WIDTH(20), .PC_BITS(5)) load_bus ();

   instr_fetch #(.INSTR_WIDTH(20), .PC_BITS(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stall       (stall),
      .load_bus    (load_bus),
      .instruction (instruction),
      .pc          (pc),
      .running     (running),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [19:0] e_instr, input logic [4:0] e_pc,
                            input logic e_run, input logic e_halt);
      check_val({tag, ".instr"},   {12'h000, instruction}, {12'h000, e_instr});
      check_val({tag, ".pc"},      {27'd0, pc},            {27'd0, e_pc});
      check_val({tag, ".running"}, {31'd0, running},       {31'd0, e_run});
      check_val({tag, ".halted"},  {31'd0, halted},        {31'd0, e_halt});
   endtask

   task automatic load_word(input logic [4:0] addr, input logic [19:0] data);
      load_bus.load_en   = 1'b1;
      load_bus.load_addr = addr;
      load_bus.load_data = data;
      tick();
      load_bus.load_en   = 1'b0;
   endtask

   // Non-HALT filler words: opcode 1..8, low bits vary with the address.
   function automatic logic [19:0] word_of(input int i);
      logic [3:0]  op;
      logic [15:0] lo;
      op = 4'(1 + (i % 8));
      lo = 16'(i * 257 + 17);
      return {op, lo};
   endfunction

   initial begin
      rst                = 1'b1;
      start              = 1'b0;
      stall              = 1'b0;
      load_bus.load_en   = 1'b0;
      load_bus.load_addr = 5'd0;
      load_bus.load_data = 20'h00000;
      tick();
      tick();
      rst = 1'b0;
      check_all("reset", 20'h00000, 5'd0, 1'b0, 1'b0);

      // Short program ending in HALT
      load_word(5'd0, 20'h10203);
      load_word(5'd1, 20'h20104);
      load_word(5'd2, 20'hF0000);
      check_all("idle_loaded", 20'h00000, 5'd0, 1'b0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_all("start", 20'h00000, 5'd0, 1'b1, 1'b0);
      tick();
      check_all("fetch0", 20'h10203, 5'd1, 1'b1, 1'b0);
      tick();
      check_all("fetch1", 20'h20104, 5'd2, 1'b1, 1'b0);
      tick();
      check_all("halt", 20'h00000, 5'd2, 1'b0, 1'b1);
      stall = 1'b1;
      tick();
      stall = 1'b0;
      check_all("halt_hold", 20'h00000, 5'd2, 1'b0, 1'b1);

      // Restart from HALTED
      start = 1'b1;
      tick();
      start = 1'b0;
      check_all("restart", 20'h00000, 5'd0, 1'b1, 1'b0);
      tick();
      check_all("refetch0", 20'h10203, 5'd1, 1'b1, 1'b0);
      tick();
      check_all("refetch1", 20'h20104, 5'd2, 1'b1, 1'b0);
      tick();
      check_all("rehalt", 20'h00000, 5'd2, 1'b0, 1'b1);

      // Full memory without HALT; last load to address 0 coincides with start
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         exp_mem[i] = word_of(i);
         load_word(5'(i), exp_mem[i]);
      end
      exp_mem[0]         = 20'h33333;
      load_bus.load_en   = 1'b1;
      load_bus.load_addr = 5'd0;
      load_bus.load_data = 20'h33333;
      start              = 1'b1;
      stall              = 1'b1;
      tick();
      load_bus.load_en = 1'b0;
      start            = 1'b0;
      stall            = 1'b0;
      check_all("load_start", 20'h00000, 5'd0, 1'b1, 1'b0);
      tick();
      check_all("f1", exp_mem[0], 5'd1, 1'b1, 1'b0);
      tick();
      check_all("f2", exp_mem[1], 5'd2, 1'b1, 1'b0);
      tick();
      check_all("f3", exp_mem[2], 5'd3, 1'b1, 1'b0);

      stall = 1'b1;
      tick();
      check_all("stall1", 20'h00000, 5'd3, 1'b1, 1'b0);
      tick();
      check_all("stall2", 20'h00000, 5'd3, 1'b1, 1'b0);
      stall = 1'b0;
      tick();
      check_all("after_stall", exp_mem[3], 5'd4, 1'b1, 1'b0);

      // start and a load while running are both ignored
      start              = 1'b1;
      load_bus.load_en   = 1'b1;
      load_bus.load_addr = 5'd5;
      load_bus.load_data = 20'hABCDE;
      tick();
      start            = 1'b0;
      load_bus.load_en = 1'b0;
      check_all("run_start_ign", exp_mem[4], 5'd5, 1'b1, 1'b0);

      for (int k = 6; k <= 33; k++) begin
         tick();
         check_all($sformatf("f%0d", k), exp_mem[(k - 1) % 32], 5'(k % 32), 1'b1, 1'b0);
      end

      // Reset mid-run together with start, stall and a HALT load to address 0
      rst                = 1'b1;
      start              = 1'b1;
      stall              = 1'b1;
      load_bus.load_en   = 1'b1;
      load_bus.load_addr = 5'd0;
      load_bus.load_data = 20'hFFFFF;
      tick();
      rst              = 1'b0;
      start            = 1'b0;
      stall            = 1'b0;
      load_bus.load_en = 1'b0;
      check_all("rst_mid_run", 20'h00000, 5'd0, 1'b0, 1'b0);
      tick();
      check_all("idle_after_rst", 20'h00000, 5'd0, 1'b0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_all("restart2", 20'h00000, 5'd0, 1'b1, 1'b0);
      tick();
      check_all("post_rst_mem0", 20'h33333, 5'd1, 1'b1, 1'b0);
      tick();
      check_all("post_rst_mem1", exp_mem[1], 5'd2, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
